// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants, arbitration encodings and write-back request type
package rf_pkg;

  localparam int RF_DW   = 8;
  localparam int RF_AW   = 3;
  localparam int RF_NREG = 1 << RF_AW;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  typedef struct packed {
    logic              valid;
    logic [RF_AW-1:0]  addr;
    logic [RF_DW-1:0]  data;
  } wb_req_t;

endpackage

// File: rtl/wb_arb2.sv
// rtl/wb_arb2.sv - two-requester arbiter (round-robin or fixed MEM priority), one-hot grant
module wb_arb2
  import rf_pkg::*;
#(
  parameter int ARB_MODE = ARB_RR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // Bit 0 is the ALU side, bit 1 the MEM side.
  logic favor_mem;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      if (ARB_MODE == ARB_FIXED) gnt = 2'b10;
      else                       gnt = favor_mem ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         favor_mem <= 1'b0;
    else if (gnt[0]) favor_mem <= 1'b1;
    else if (gnt[1]) favor_mem <= 1'b0;
  end

endmodule

// File: rtl/rf_wb_ctrl.sv
// rtl/rf_wb_ctrl.sv - RF write-back arbitration, output register and RAW/WAW scoreboard
// Optional same-cycle forwarding from the RF write port with RF_WB_BYPASS_EN.
module rf_wb_ctrl
  import rf_pkg::*;
#(
  parameter int DW       = RF_DW,
  parameter int AW       = RF_AW,
  parameter int NREG     = RF_NREG,
  parameter int ARB_MODE = ARB_RR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_addr,
  input  logic [DW-1:0]   alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [AW-1:0]   mem_addr,
  input  logic [DW-1:0]   mem_data,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_dst,
  input  logic [AW-1:0]   iss_src0,
  input  logic [AW-1:0]   iss_src1,
  output logic            stall,
  output logic            rf_w_en,
  output logic [AW-1:0]   rf_w_addr,
  output logic [DW-1:0]   rf_w_data,
  output logic [NREG-1:0] pend_map
`ifdef RF_WB_BYPASS_EN
  ,
  output logic            byp_sel0,
  output logic            byp_sel1,
  output logic [DW-1:0]   byp_data
`endif
);

  localparam logic [NREG-1:0] NONZERO_MASK = {{(NREG-1){1'b1}}, 1'b0};

  wb_req_t    alu_req;
  wb_req_t    mem_req;
  wb_req_t    win;
  logic [1:0] gnt;

  assign alu_req = '{valid: alu_valid, addr: alu_addr, data: alu_data};
  assign mem_req = '{valid: mem_valid, addr: mem_addr, data: mem_data};

  wb_arb2 #(.ARB_MODE(ARB_MODE)) u_arb (
    .clk (clk),
    .rst (rst),
    .req ({mem_valid, alu_valid}),
    .gnt (gnt)
  );

  assign alu_ready = gnt[0];
  assign mem_ready = gnt[1];

  always_comb begin
    win = alu_req;
    if (gnt[1]) win = mem_req;
    win.valid = |gnt;
  end

  // Writes to register 0 complete the handshake but never reach the RF port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_w_en   <= 1'b0;
      rf_w_addr <= '0;
      rf_w_data <= '0;
    end else begin
      rf_w_en <= win.valid && (win.addr != '0);
      if (win.valid && (win.addr != '0)) begin
        rf_w_addr <= win.addr;
        rf_w_data <= win.data;
      end
    end
  end

  logic byp0;
  logic byp1;
  logic src_hz0;
  logic src_hz1;

`ifdef RF_WB_BYPASS_EN
  assign byp0     = rf_w_en && (rf_w_addr == iss_src0);
  assign byp1     = rf_w_en && (rf_w_addr == iss_src1);
  assign byp_sel0 = (iss_src0 != '0) && pend_map[iss_src0] && byp0;
  assign byp_sel1 = (iss_src1 != '0) && pend_map[iss_src1] && byp1;
  assign byp_data = rf_w_data;
`else
  assign byp0 = 1'b0;
  assign byp1 = 1'b0;
`endif

  assign src_hz0 = (iss_src0 != '0) && pend_map[iss_src0] && !byp0;
  assign src_hz1 = (iss_src1 != '0) && pend_map[iss_src1] && !byp1;
  // Destination term is the WAW check and is never forwarded around.
  assign stall   = iss_valid && (src_hz0 || src_hz1 || pend_map[iss_dst]);

  logic [NREG-1:0] clr_vec;
  logic [NREG-1:0] set_vec;

  always_comb begin
    clr_vec = '0;
    set_vec = '0;
    if (rf_w_en) clr_vec[rf_w_addr] = 1'b1;
    if (iss_valid && !stall && (iss_dst != '0)) set_vec[iss_dst] = 1'b1;
  end

  // Set is applied after clear so a new producer supersedes the landing write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_map <= '0;
    else     pend_map <= ((pend_map & ~clr_vec) | set_vec) & NONZERO_MASK;
  end

endmodule
